// File: rtl/penc_irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : penc_irq_ctrl_pkg
//  Description : Shared types and default sizing for the priority-encoded
//                interrupt controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package penc_irq_ctrl_pkg;

    // Default number of request lines and matching index width
    localparam int c_N     = 4;
    localparam int c_IDX_W = 2;

    // Presentation FSM: IDLE has nothing offered, PRESENT holds a frozen index
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

endpackage : penc_irq_ctrl_pkg
`default_nettype wire

// File: rtl/penc_irq_ctrl_penc_core.sv
`default_nettype none
// ============================================================================
//  Module      : penc_core
//  Description : Combinational priority encoder. Returns the index of the
//                highest set bit (bit N-1 wins) and a nonzero flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module penc_core
    import penc_irq_ctrl_pkg::*;
#(
    parameter int N     = c_N,
    parameter int IDX_W = c_IDX_W
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             nz
);

    // Scan upward so the highest set bit is the last one to overwrite idx
    always_comb begin
        idx = '0;
        nz  = |req;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule : penc_core
`default_nettype wire

// File: rtl/penc_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : penc_irq_ctrl
//  Description : Edge-detecting interrupt controller. Rising request edges
//                latch into a pending register; the highest-priority
//                eligible pending line is presented on a/valid and cleared
//                when the consumer acknowledges it. Re-rises on a line that
//                is still pending set a sticky overflow flag.
//  Options     : PENC_IRQ_MASK_EN - adds a per-line mask input (1 = blocked).
//                Masked lines still pend and overflow but are never presented.
//  Revision    : 1.0 - initial release
// ============================================================================
module penc_irq_ctrl
    import penc_irq_ctrl_pkg::*;
#(
    parameter int N     = c_N,
    parameter int IDX_W = c_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     y,
    input  logic             ack,
`ifdef PENC_IRQ_MASK_EN
    input  logic [N-1:0]     mask,
`endif
    output logic             valid,
    output logic [IDX_W-1:0] a,
    output logic [N-1:0]     pend,
    output logic [N-1:0]     ovf
);

    logic [N-1:0]     r_y_q;
    logic [N-1:0]     r_pend;
    logic [N-1:0]     r_ovf;
    logic [IDX_W-1:0] r_a;
    state_t           r_state;

    logic [N-1:0]     w_rise;
    logic [N-1:0]     w_clr;
    logic [N-1:0]     w_elig;
    logic [IDX_W-1:0] w_idx;
    logic             w_nz;
    logic [IDX_W-1:0] w_a_nxt;
    state_t           w_state_nxt;

    assign w_rise = y & ~r_y_q;

`ifdef PENC_IRQ_MASK_EN
    assign w_elig = r_pend & ~mask;
`else
    assign w_elig = r_pend;
`endif

    // Acknowledge clears only the line currently presented; ack in IDLE is ignored
    always_comb begin
        w_clr = '0;
        if ((r_state == PRESENT) && ack) begin
            w_clr[r_a] = 1'b1;
        end
    end

    penc_core #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_penc_core (
        .req (w_elig),
        .idx (w_idx),
        .nz  (w_nz)
    );

    // Input history, pending and sticky overflow registers; a new rise beats a same-edge clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_q  <= '0;
            r_pend <= '0;
            r_ovf  <= '0;
        end else begin
            r_y_q  <= y;
            r_pend <= (r_pend & ~w_clr) | w_rise;
            r_ovf  <= r_ovf | (w_rise & r_pend & ~w_clr);
        end
    end

    // FSM state and presented-index register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
        end
    end

    // Next state: capture the index on entry to PRESENT and hold it until ack
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        case (r_state)
            IDLE: begin
                if (w_nz) begin
                    w_state_nxt = PRESENT;
                    w_a_nxt     = w_idx;
                end
            end
            PRESENT: begin
                if (ack) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign valid = (r_state == PRESENT);
    assign a     = r_a;
    assign pend  = r_pend;
    assign ovf   = r_ovf;

endmodule : penc_irq_ctrl
`default_nettype wire

// File: tb/tb_penc_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_penc_irq_ctrl
//  Description : Directed self-checking bench for penc_irq_ctrl.
//  Options     : PENC_IRQ_MASK_EN - also drives the mask port and runs the
//                mask scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_penc_irq_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] y;
    logic       ack;
    logic       valid;
    logic [1:0] a;
    logic [3:0] pend;
    logic [3:0] ovf;
`ifdef PENC_IRQ_MASK_EN
    logic [3:0] mask;
`endif

    int n_total;
    int n_bad;

    penc_irq_ctrl #(
        .N     (4),
        .IDX_W (2)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .y     (y),
        .ack   (ack),
`ifdef PENC_IRQ_MASK_EN
        .mask  (mask),
`endif
        .valid (valid),
        .a     (a),
        .pend  (pend),
        .ovf   (ovf)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        y       = 4'b0000;
        ack     = 1'b0;
`ifdef PENC_IRQ_MASK_EN
        mask    = 4'b0000;
`endif
        tick();
        tick();
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_a",     32'(a),     32'd0);
        chk("rst_pend",  32'(pend),  32'd0);
        chk("rst_ovf",   32'(ovf),   32'd0);
        rst_n = 1'b1;

        // Single request, ack held high from the start: ignored while IDLE
        y = 4'b0001; ack = 1'b1;
        tick();
        chk("t1_pend_e1",  32'(pend),  32'h1);
        chk("t1_valid_e1", 32'(valid), 32'd0);
        tick();
        chk("t1_valid_e2", 32'(valid), 32'd1);
        chk("t1_a_e2",     32'(a),     32'd0);
        chk("t1_idle_ack", 32'(pend),  32'h1);
        tick();
        chk("t1_pend_ack",  32'(pend),  32'h0);
        chk("t1_valid_ack", 32'(valid), 32'd0);
        ack = 1'b0; y = 4'b0000;
        tick();

        // Two simultaneous rises: higher first, one IDLE cycle, then lower
        y = 4'b0101;
        tick();
        chk("t2_pend", 32'(pend), 32'h5);
        tick();
        chk("t2_a_hi", 32'(a), 32'd2);
        ack = 1'b1;
        tick();
        chk("t2_idle",  32'(valid), 32'd0);
        chk("t2_pend1", 32'(pend),  32'h1);
        ack = 1'b0;
        tick();
        chk("t2_valid_lo", 32'(valid), 32'd1);
        chk("t2_a_lo",     32'(a),     32'd0);
        ack = 1'b1;
        tick();
        chk("t2_pend_done", 32'(pend), 32'h0);
        ack = 1'b0; y = 4'b0000;
        tick();

        // Higher-priority arrival during PRESENT does not move a
        y = 4'b0001;
        tick();
        tick();
        chk("t3_a0", 32'(a), 32'd0);
        y = 4'b1001;
        tick();
        chk("t3_a_frozen", 32'(a),    32'd0);
        chk("t3_pend",     32'(pend), 32'h9);
        ack = 1'b1;
        tick();
        chk("t3_pend_ack", 32'(pend), 32'h8);
        ack = 1'b0;
        tick();
        chk("t3_a3", 32'(a), 32'd3);
        ack = 1'b1;
        tick();
        ack = 1'b0; y = 4'b0000;
        tick();
        chk("t3_clear", 32'(pend), 32'h0);

        // Rise on the same edge as its clear: set wins, no overflow
        y = 4'b0001;
        tick();
        y = 4'b0000;
        tick();
        chk("t4_present", 32'(valid), 32'd1);
        y = 4'b0001; ack = 1'b1;
        tick();
        chk("t4_setwins", 32'(pend),  32'h1);
        chk("t4_no_ovf",  32'(ovf),   32'h0);
        chk("t4_idle",    32'(valid), 32'd0);
        ack = 1'b0;
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0; y = 4'b0000;
        tick();
        chk("t4_clear", 32'(pend), 32'h0);

        // Re-rise on a pending line sets the sticky overflow flag
        y = 4'b0010;
        tick();
        y = 4'b0000;
        tick();
        y = 4'b0010;
        tick();
        chk("t5_ovf",  32'(ovf),  32'h2);
        chk("t5_pend", 32'(pend), 32'h2);
        ack = 1'b1;
        tick();
        ack = 1'b0; y = 4'b0000;
        tick();
        tick();
        chk("t5_ovf_sticky", 32'(ovf),  32'h2);
        chk("t5_pend_clr",   32'(pend), 32'h0);

        // Asynchronous reset mid-presentation, line held high across release
        y = 4'b0100;
        tick();
        tick();
        chk("t6_pre_valid", 32'(valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(valid), 32'd0);
        chk("t6_rst_a",     32'(a),     32'd0);
        chk("t6_rst_pend",  32'(pend),  32'h0);
        chk("t6_rst_ovf",   32'(ovf),   32'h0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("t6_pend_e1",  32'(pend),  32'h4);
        chk("t6_valid_e1", 32'(valid), 32'd0);
        tick();
        chk("t6_valid_e2", 32'(valid), 32'd1);
        chk("t6_a_e2",     32'(a),     32'd2);
        ack = 1'b1;
        tick();
        ack = 1'b0; y = 4'b0000;
        tick();

`ifdef PENC_IRQ_MASK_EN
        // Masked line pends but is skipped until the mask is lifted
        mask = 4'b1000; y = 4'b1010;
        tick();
        chk("t7_pend", 32'(pend), 32'hA);
        tick();
        chk("t7_a1", 32'(a), 32'd1);
        mask = 4'b0000;
        tick();
        chk("t7_a_frozen", 32'(a), 32'd1);
        ack = 1'b1;
        tick();
        chk("t7_pend_ack", 32'(pend), 32'h8);
        ack = 1'b0;
        tick();
        chk("t7_a3", 32'(a), 32'd3);
        ack = 1'b1;
        tick();
        ack = 1'b0; y = 4'b0000;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_penc_irq_ctrl
`default_nettype wire

// File: doc/penc_irq_ctrl.md
PENC_IRQ_CTRL -- requirements
Module: penc_irq_ctrl

Interface
REQ-001 Parameter N, default 4: number of request lines.
REQ-002 Parameter IDX_W, default 2: index width, equal to clog2(N).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 y  input  N  raw request lines, bit N-1 highest priority.
REQ-006 ack  input  1  consumer accepts the presented index.
REQ-007 valid  output  1  index on a is valid.
REQ-008 a  output  IDX_W  encoded index of the highest-priority pending request.
REQ-009 pend  output  N  pending-request register.
REQ-010 ovf  output  N  sticky overflow flags, one per line.

Function
REQ-011 Register y_q shall hold y from the previous clock; rise = y & ~y_q.
REQ-012 pend bit i shall set on the clock edge where rise[i]=1, and clear on the edge where ack=1, valid=1 and a=i.
REQ-013 Simultaneous rise[i] and clear of bit i: set shall win, bit stays pending.
REQ-014 Rise on an already-set pend bit (not being cleared that edge) shall set ovf[i], which holds until reset.
REQ-015 FSM states: IDLE (valid=0) and PRESENT (valid=1).
REQ-016 IDLE -> PRESENT on an edge where the eligible pend vector (pend after masking) is nonzero; a shall load the highest set index on that edge.
REQ-017 PRESENT -> IDLE on an edge with ack=1; no other exit.
REQ-018 In PRESENT, a shall stay frozen regardless of new higher-priority requests.
REQ-019 ack in IDLE shall be ignored.
REQ-020 Latency: a rise sampled at edge k shall set pend after edge k, and valid shall go high after edge k+1.
REQ-021 After ack there shall be at least one IDLE cycle before the next valid.

Reset
REQ-022 Asserting rst_n=0 shall immediately force pend=0, ovf=0, y_q=0, state=IDLE, valid=0 and a=0, including mid-presentation.
REQ-023 A line already high at reset release shall count as a rise at the first clock edge.

Configuration
REQ-024 Macro PENC_IRQ_MASK_EN, when defined, shall add input mask (N bits, 1 = blocked). Eligible pend = pend & ~mask.
REQ-025 With the macro defined, masked lines shall still latch into pend and ovf but shall never be presented. A mask change during PRESENT shall not alter a.
REQ-026 Without the macro, the mask port shall be absent and eligible pend = pend.

Structure
REQ-027 A shared package shall hold the FSM state typedef (IDLE, PRESENT) and the default N and IDX_W constants.
REQ-028 The priority-encode function shall be a sub-module, penc_core: N-bit input, IDX_W-bit index and nonzero flag, combinational; instantiated once on the eligible pend.

Verification
REQ-029 Reset, then y=0001 at edge 1 -> pend=0001 after edge 1, valid=1 and a=00 after edge 2; ack for one cycle -> pend=0000, valid=0.
REQ-030 y=0101 rising together -> a=10; after ack, one IDLE cycle, then a=00; after second ack, pend=0000.
REQ-031 In PRESENT with a=00, y goes 1000 -> a stays 00, pend=1001; after ack -> a=11 next presentation.
REQ-032 y bit1 pulses 0->1->0->1 while pend[1]=1 and no ack -> ovf=0010, sticky until rst_n=0.
REQ-033 rst_n pulsed low while valid=1 -> valid, a, pend and ovf all 0 immediately; y held at 0100 -> valid=1, a=10 two edges after release.
REQ-034 With PENC_IRQ_MASK_EN defined, mask=1000 and y=1010 -> a=01, pend=1010; after ack and mask=0000 -> a=11.
